// File: rtl/spwm_duty_decoder_if.sv
// Bundles the PWM input line and the duty/period report of spwm_duty_decoder.
// The slave side is the decoder; the master side drives the line and consumes reports.
interface spwm_duty_decoder_if #(
  parameter int CNT_W = 13
);
  logic             pwm_in;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             duty_valid;
  logic             stuck;

  modport slave (
    input  pwm_in,
    output duty,
    output period,
    output duty_valid,
    output stuck
  );

  modport master (
    output pwm_in,
    input  duty,
    input  period,
    input  duty_valid,
    input  stuck
  );
endinterface

// File: rtl/spwm_duty_decoder.sv
// Measures high time and period of an asynchronous PWM line between rising edges.
// Optional glitch filter on the synchronized line: define PWM_GLITCH_FILTER_EN.
module spwm_duty_decoder #(
  parameter int CNT_W      = 13,
  parameter int TIMEOUT    = 8191,
  parameter int GLITCH_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  spwm_duty_decoder_if.slave  bus
);

`ifdef PWM_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  // Cycles until pwm_d reflects the real line rather than the reset zeros in the input path.
  localparam int SETTLE = 3 + (FILT_ON ? GLITCH_LEN : 0);
  localparam int SET_W  = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) return v + ONE;
    return v;
  endfunction

  logic             sync1_q, sync2_q;
  logic             pwm_s, pwm_f, pwm_d_q, rise;
  logic [SET_W-1:0] settle_q;
  logic             settled;
  state_t           state_q;
  logic [CNT_W-1:0] per_cnt_q, hi_cnt_q;
  logic [CNT_W-1:0] per_cnt_d, hi_cnt_d;
  logic [CNT_W-1:0] duty_q, period_q;
  logic             dv_q, stuck_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign pwm_s = sync2_q;

`ifdef PWM_GLITCH_FILTER_EN
  localparam int GW = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GLITCH_LEN - 1);

  logic          filt_q;
  logic [GW-1:0] gcnt_q;

  // Flip only after pwm_s has disagreed with the filtered level GLITCH_LEN cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      gcnt_q <= '0;
    end else if (pwm_s != filt_q) begin
      if (gcnt_q == G_LAST) begin
        filt_q <= pwm_s;
        gcnt_q <= '0;
      end else begin
        gcnt_q <= gcnt_q + GW'(1);
      end
    end else begin
      gcnt_q <= '0;
    end
  end

  assign pwm_f = filt_q;
`else
  assign pwm_f = pwm_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_d_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      pwm_d_q <= pwm_f;
      if (!settled) settle_q <= settle_q + SET_W'(1);
    end
  end

  assign settled   = (settle_q == SET_W'(SETTLE));
  assign rise      = pwm_f & ~pwm_d_q & settled;
  assign per_cnt_d = sat_inc(per_cnt_q, 1'b1);
  assign hi_cnt_d  = sat_inc(hi_cnt_q, pwm_f);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      dv_q      <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q   <= MEAS;
            per_cnt_q <= ONE;
            hi_cnt_q  <= ONE;
          end else begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
          end
        end
        MEAS: begin
          if (rise) begin
            duty_q    <= hi_cnt_q;
            period_q  <= per_cnt_q;
            dv_q      <= 1'b1;
            per_cnt_q <= ONE;
            hi_cnt_q  <= ONE;
          end else if (per_cnt_q >= TMO) begin
            state_q   <= STUCK;
            duty_q    <= pwm_f ? TMO : '0;
            period_q  <= TMO;
            dv_q      <= 1'b1;
            stuck_q   <= 1'b1;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
          end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
          end
        end
        STUCK: begin
          if (rise) begin
            state_q   <= MEAS;
            stuck_q   <= 1'b0;
            per_cnt_q <= ONE;
            hi_cnt_q  <= ONE;
          end else if (per_cnt_q >= TMO_M1) begin
            // Counting restarts from 0 here, so TIMEOUT-1 keeps repeats exactly TIMEOUT apart.
            duty_q    <= pwm_f ? TMO : '0;
            period_q  <= TMO;
            dv_q      <= 1'b1;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
          end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          per_cnt_q <= '0;
          hi_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.duty       = duty_q;
  assign bus.period     = period_q;
  assign bus.duty_valid = dv_q;
  assign bus.stuck      = stuck_q;

  a_duty_le_period: assert property (@(posedge clk) disable iff (rst) duty_q <= period_q);
  a_stuck_state:    assert property (@(posedge clk) disable iff (rst) stuck_q |-> (state_q == STUCK));

endmodule

// File: tb/tb_spwm_duty_decoder.sv
// Drives PWM waveforms into spwm_duty_decoder and checks every report against a
// model derived from the rising-edge list of the logged input waveform.
module tb_spwm_duty_decoder;

  localparam int CNT_W = 13;
  localparam int T     = 8191;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int G = 3;
`else
  localparam int G = 0;
`endif
  // Raw-line index j shows up as a decision at DUT cycle j+OFF and is sampled one edge later.
  localparam int OFF = 2 + G;

  typedef struct {
    int m;
    int duty;
    int period;
    int stuck;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spwm_duty_decoder_if #(.CNT_W(CNT_W)) bus ();

  spwm_duty_decoder #(
    .CNT_W(CNT_W),
    .TIMEOUT(T),
    .GLITCH_LEN(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];
  int  lvl_q[$];
  int  wl_q[$];
  int  wn_q[$];
  int  exp_stuck;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic add(input int lv, input int len);
    wl_q.push_back(lv);
    wn_q.push_back(len);
  endtask

  function automatic void push_ev(input int t, input int d, input int p, input int s, input int n);
    ev_t e;
    e.m      = t + OFF + 1;
    e.duty   = d;
    e.period = p;
    e.stuck  = s;
    if (e.m <= n) exp_q.push_back(e);
  endfunction

  // Expected reports from the logged line: filter, list rising edges, then apply
  // the period/timeout rules between consecutive edges.
  function automatic void build_expected(input int n);
    int flt[];
    int rises[$];
    int jmax, prev, all_opp, a, b, sum, t;
    int last_stuck, last_rise;
    exp_q.delete();
    jmax = n - 1 - G;
    flt  = new[n];
    prev = 0;
    for (int j = 0; j <= jmax; j++) begin
      if (G == 0) begin
        flt[j] = lvl_q[j];
      end else begin
        all_opp = 1;
        for (int i = 0; i < G; i++)
          if (lvl_q[j+i] == prev) all_opp = 0;
        if (all_opp != 0) prev = 1 - prev;
        flt[j] = prev;
      end
    end
    for (int j = 1; j <= jmax; j++)
      if (flt[j] == 1 && flt[j-1] == 0) rises.push_back(j);
    last_stuck = -1;
    last_rise  = -1;
    for (int k = 0; k < rises.size(); k++) begin
      a = rises[k];
      if (a + OFF + 1 <= n) last_rise = a;
      b = (k + 1 < rises.size()) ? rises[k+1] : -1;
      if (b >= 0 && (b - a) <= T) begin
        sum = 0;
        for (int i = a; i < b; i++) sum += flt[i];
        push_ev(b, sum, b - a, 0, n);
      end else begin
        for (t = a + T; (b < 0) ? (t <= jmax) : (t < b); t += T) begin
          push_ev(t, (flt[t] != 0) ? T : 0, T, 1, n);
          if (t + OFF + 1 <= n) last_stuck = t;
        end
      end
    end
    exp_stuck = (last_stuck > last_rise) ? 1 : 0;
  endfunction

  task automatic run_seg(input string name);
    ev_t e;
    int  m;
    int  ed, ep;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " rst duty"},   int'(bus.duty), 0);
    chk({name, " rst period"}, int'(bus.period), 0);
    chk({name, " rst valid"},  int'(bus.duty_valid), 0);
    chk({name, " rst stuck"},  int'(bus.stuck), 0);
    rst = 1'b0;
    lvl_q.delete();
    obs_q.delete();
    m = 0;
    for (int i = 0; i < wl_q.size(); i++) begin
      for (int c = 0; c < wn_q[i]; c++) begin
        bus.pwm_in = wl_q[i][0];
        lvl_q.push_back(wl_q[i]);
        @(posedge clk);
        #1;
        m++;
        if (bus.duty_valid === 1'b1) begin
          e.m      = m;
          e.duty   = int'(bus.duty);
          e.period = int'(bus.period);
          e.stuck  = int'(bus.stuck);
          obs_q.push_back(e);
        end
      end
    end
    wl_q.delete();
    wn_q.delete();
    build_expected(m);
    chk({name, " strobe count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s ev%0d cycle", name, i),  obs_q[i].m,      exp_q[i].m);
      chk($sformatf("%s ev%0d duty", name, i),   obs_q[i].duty,   exp_q[i].duty);
      chk($sformatf("%s ev%0d period", name, i), obs_q[i].period, exp_q[i].period);
      chk($sformatf("%s ev%0d stuck", name, i),  obs_q[i].stuck,  exp_q[i].stuck);
    end
    ed = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].duty   : 0;
    ep = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].period : 0;
    chk({name, " hold duty"},   int'(bus.duty), ed);
    chk({name, " hold period"}, int'(bus.period), ep);
    chk({name, " final stuck"}, int'(bus.stuck), exp_stuck);
  endtask

  initial begin
    int p, h;
    bus.pwm_in = 1'b0;

    add(0, 20);
    repeat (4) begin add(1, 1234); add(0, 3767); end
    add(0, 100);
    run_seg("frame");

    add(0, 10);
    add(1, 1);    add(0, 5000);
    add(1, 2500); add(0, 2501);
    add(1, 5000); add(0, 1);
    add(1, 1234); add(0, 16000);
    add(1, 9000); add(0, 200);
    add(1, 100);  add(0, 400);
    add(1, 30);
    run_seg("sweep_stuck");

    add(1, 40);   add(0, 60);
    add(1, 100);  add(0, 8091);
    add(1, 20);   add(0, 30);
    add(1, 5);    add(0, 10);
    run_seg("rst_high_tmo");

    add(0, 10);
    repeat (3) begin
      add(1, 120); add(0, 1); add(1, 80); add(0, 2); add(1, 50); add(0, 300);
    end
    add(1, 5);
    add(0, 10);
    run_seg("glitch");

    add(0, 20);
    repeat (10) begin
      p = int'($urandom_range(400, 2));
      h = int'($urandom_range(p - 1, 1));
      add(1, h);
      add(0, p - h);
    end
    add(1, 3);
    add(0, 5);
    run_seg("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
